// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, dcache and memory-side signals of the tagged memory arbiter
interface mem_arbiter_if;
  logic [1:0]  icache2arb_command;
  logic [31:0] icache2arb_addr;
  logic [3:0]  arb2icache_response;
  logic [63:0] arb2icache_data;
  logic [3:0]  arb2icache_tag;
  logic [1:0]  dcache2arb_command;
  logic [31:0] dcache2arb_addr;
  logic [63:0] dcache2arb_data;
  logic [3:0]  arb2dcache_response;
  logic [63:0] arb2dcache_data;
  logic [3:0]  arb2dcache_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [1:0]  arb_grant;
  modport slave (
    input  icache2arb_command, icache2arb_addr, dcache2arb_command, dcache2arb_addr, dcache2arb_data,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    output arb2icache_response, arb2icache_data, arb2icache_tag,
           arb2dcache_response, arb2dcache_data, arb2dcache_tag,
           proc2mem_command, proc2mem_addr, proc2mem_data, arb_grant
  );
  modport master (
    output icache2arb_command, icache2arb_addr, dcache2arb_command, dcache2arb_addr, dcache2arb_data,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    input  arb2icache_response, arb2icache_data, arb2icache_tag,
           arb2dcache_response, arb2dcache_data, arb2dcache_tag,
           proc2mem_command, proc2mem_addr, proc2mem_data, arb_grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one tagged memory port between icache and dcache; MEM_ARB_ROUND_ROBIN_EN alternates grants on contention
module mem_arbiter #(
  parameter int NUM_TAGS        = 15,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  logic [NUM_TAGS:0] r_valid;
  logic [NUM_TAGS:0] r_owner;
  logic [CW-1:0]     r_icnt;
  logic [CW-1:0]     r_dcnt;
  logic              w_i_elig;
  logic              w_d_elig;
  logic              w_gnt_i;
  logic              w_gnt_d;
  logic              w_acc;
  logic              w_done;
  logic              w_own;
  logic [1:0]        w_cmd;
  logic [3:0]        w_tag;
  assign w_i_elig = bus.icache2arb_command != BUS_NONE &&
                    (bus.icache2arb_command == BUS_STORE || r_icnt < CW'(MAX_OUTSTANDING));
  assign w_d_elig = bus.dcache2arb_command != BUS_NONE &&
                    (bus.dcache2arb_command == BUS_STORE || r_dcnt < CW'(MAX_OUTSTANDING));
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_gnt_d = w_d_elig && (!w_i_elig || !r_last_d);
  // remember the most recent winner so contention alternates
  always_ff @(posedge clock or posedge reset)
    if (reset) r_last_d <= 1'b0;
    else if (w_gnt_i || w_gnt_d) r_last_d <= w_gnt_d;
`else
  assign w_gnt_d = w_d_elig;
`endif
  assign w_gnt_i = w_i_elig && !w_gnt_d;
  assign w_cmd   = w_gnt_d ? bus.dcache2arb_command : w_gnt_i ? bus.icache2arb_command : BUS_NONE;
  assign w_tag   = bus.mem2proc_tag;
  assign w_done  = w_tag != 4'd0 && w_tag <= 4'(NUM_TAGS) && r_valid[w_tag];
  assign w_own   = r_owner[w_tag];
  assign w_acc   = w_cmd == BUS_LOAD && bus.mem2proc_response != 4'd0 &&
                   bus.mem2proc_response <= 4'(NUM_TAGS);
  assign bus.arb_grant           = {w_gnt_d, w_gnt_i};
  assign bus.proc2mem_command    = w_cmd;
  assign bus.proc2mem_addr       = w_gnt_d ? bus.dcache2arb_addr : w_gnt_i ? bus.icache2arb_addr : '0;
  assign bus.proc2mem_data       = w_gnt_d ? bus.dcache2arb_data : '0;
  assign bus.arb2icache_response = w_gnt_i ? bus.mem2proc_response : '0;
  assign bus.arb2dcache_response = w_gnt_d ? bus.mem2proc_response : '0;
  assign bus.arb2icache_tag      = w_done && !w_own ? w_tag : '0;
  assign bus.arb2icache_data     = w_done && !w_own ? bus.mem2proc_data : '0;
  assign bus.arb2dcache_tag      = w_done && w_own ? w_tag : '0;
  assign bus.arb2dcache_data     = w_done && w_own ? bus.mem2proc_data : '0;
  // owner table and per-requester load counters; a new accept on a completing tag wins
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_valid <= '0;
      r_owner <= '0;
      r_icnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      if (w_done) r_valid[w_tag] <= 1'b0;
      if (w_acc) begin
        r_valid[bus.mem2proc_response] <= 1'b1;
        r_owner[bus.mem2proc_response] <= w_gnt_d;
      end
      r_icnt <= r_icnt + CW'(w_acc && w_gnt_i) - CW'(w_done && !w_own);
      r_dcnt <= r_dcnt + CW'(w_acc && w_gnt_d) - CW'(w_done && w_own);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner sequences and randomized run against a tag-map reference model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  mem_arbiter_if bus();
  mem_arbiter dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  int owner[int];
  int cnt[2];
  int last_d;
  logic [1:0]  s_grant, s_pcmd;
  logic [31:0] s_paddr;
  logic [63:0] s_pdata, s_idata, s_ddata;
  logic [3:0]  s_iresp, s_dresp, s_itag, s_dtag;
  typedef struct {
    logic [1:0]  ic;
    logic [31:0] ia;
    logic [1:0]  dc;
    logic [31:0] da;
    logic [63:0] dd;
    logic [3:0]  rs;
    logic [3:0]  mt;
    logic [63:0] md;
    logic [1:0]  grant;
    logic [1:0]  pcmd;
    logic [31:0] paddr;
    logic [63:0] pdata;
    logic [3:0]  iresp;
    logic [3:0]  dresp;
    logic [3:0]  itag;
    logic [63:0] idata;
    logic [3:0]  dtag;
    logic [63:0] ddata;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic model_reset();
    owner.delete();
    cnt[0] = 0;
    cnt[1] = 0;
    last_d = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc, input logic [31:0] da,
                       input logic [63:0] dd, input logic [3:0] rs, input logic [3:0] mt, input logic [63:0] md);
    bit ie, de, gi, gd;
    int own;
    logic [1:0] ecmd;
    bus.icache2arb_command = ic;
    bus.icache2arb_addr    = ia;
    bus.dcache2arb_command = dc;
    bus.dcache2arb_addr    = da;
    bus.dcache2arb_data    = dd;
    bus.mem2proc_response  = rs;
    bus.mem2proc_tag       = mt;
    bus.mem2proc_data      = md;
    @(negedge clk);
    ie = ic != 0 && (ic == 2 || cnt[0] < 8);
    de = dc != 0 && (dc == 2 || cnt[1] < 8);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    gd = de && (!ie || last_d == 0);
`else
    gd = de;
`endif
    gi = ie && !gd;
    ecmd = gd ? dc : gi ? ic : 2'd0;
    own = (mt != 0 && owner.exists(int'(mt))) ? owner[int'(mt)] : -1;
    s_grant = bus.arb_grant;
    s_pcmd  = bus.proc2mem_command;
    s_paddr = bus.proc2mem_addr;
    s_pdata = bus.proc2mem_data;
    s_iresp = bus.arb2icache_response;
    s_dresp = bus.arb2dcache_response;
    s_itag  = bus.arb2icache_tag;
    s_idata = bus.arb2icache_data;
    s_dtag  = bus.arb2dcache_tag;
    s_ddata = bus.arb2dcache_data;
    chk("m_grant", s_grant, {gd, gi});
    chk("m_pcmd",  s_pcmd, ecmd);
    chk("m_paddr", s_paddr, gd ? da : gi ? ia : 32'd0);
    chk("m_pdata", s_pdata, gd ? dd : 64'd0);
    chk("m_iresp", s_iresp, gi ? rs : 4'd0);
    chk("m_dresp", s_dresp, gd ? rs : 4'd0);
    chk("m_itag",  s_itag, own == 0 ? mt : 4'd0);
    chk("m_idata", s_idata, own == 0 ? md : 64'd0);
    chk("m_dtag",  s_dtag, own == 1 ? mt : 4'd0);
    chk("m_ddata", s_ddata, own == 1 ? md : 64'd0);
    if (own >= 0) begin
      owner.delete(int'(mt));
      cnt[own]--;
    end
    if ((gi || gd) && ecmd == 2'd1 && rs != 0) begin
      owner[int'(rs)] = int'(gd);
      cnt[int'(gd)]++;
    end
    if (gi || gd) last_d = int'(gd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ic, dc;
    logic [3:0] rs, mt;
    int keys[$];
    bus.icache2arb_command = '0;
    bus.icache2arb_addr    = '0;
    bus.dcache2arb_command = '0;
    bus.dcache2arb_addr    = '0;
    bus.dcache2arb_data    = '0;
    bus.mem2proc_response  = '0;
    bus.mem2proc_tag       = '0;
    bus.mem2proc_data      = '0;
    tbl[0] = '{1, 32'h400, 0, 0, 0, 1, 0, 0,                         2'b01, 1, 32'h400, 0,     1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0,                                2'b00, 0, 0, 0,           0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0,                                2'b00, 0, 0, 0,           0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 1, 64'hdeadbeefcafebabe,             2'b00, 0, 0, 0,           0, 0, 1, 64'hdeadbeefcafebabe, 0, 0};
    tbl[4] = '{1, 32'h400, 1, 32'h800, 0, 2, 0, 0,                   2'b10, 1, 32'h800, 0,     0, 2, 0, 0, 0, 0};
    tbl[5] = '{1, 32'h400, 0, 0, 0, 3, 0, 0,                         2'b01, 1, 32'h400, 0,     3, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 3, 64'h1111,                        2'b00, 0, 0, 0,           0, 0, 3, 64'h1111, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 2, 64'h2222,                        2'b00, 0, 0, 0,           0, 0, 0, 0, 2, 64'h2222};
    tbl[8] = '{0, 0, 2, 32'h100, 64'h55, 4, 0, 0,                    2'b10, 2, 32'h100, 64'h55, 0, 4, 0, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 4, 64'h9999,                        2'b00, 0, 0, 0,           0, 0, 0, 0, 0, 0};
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 1, 64'h77);
    chk("rst_itag", s_itag, 4'd0);
    chk("rst_dtag", s_dtag, 4'd0);
    foreach (tbl[i]) begin
      apply(tbl[i].ic, tbl[i].ia, tbl[i].dc, tbl[i].da, tbl[i].dd, tbl[i].rs, tbl[i].mt, tbl[i].md);
      chk($sformatf("tbl%0d_grant", i), s_grant, tbl[i].grant);
      chk($sformatf("tbl%0d_pcmd", i),  s_pcmd,  tbl[i].pcmd);
      chk($sformatf("tbl%0d_paddr", i), s_paddr, tbl[i].paddr);
      chk($sformatf("tbl%0d_pdata", i), s_pdata, tbl[i].pdata);
      chk($sformatf("tbl%0d_iresp", i), s_iresp, tbl[i].iresp);
      chk($sformatf("tbl%0d_dresp", i), s_dresp, tbl[i].dresp);
      chk($sformatf("tbl%0d_itag", i),  s_itag,  tbl[i].itag);
      chk($sformatf("tbl%0d_idata", i), s_idata, tbl[i].idata);
      chk($sformatf("tbl%0d_dtag", i),  s_dtag,  tbl[i].dtag);
      chk($sformatf("tbl%0d_ddata", i), s_ddata, tbl[i].ddata);
    end
    for (int t = 1; t <= 8; t++) begin
      apply(1, 32'h1000 + t, 0, 0, 0, 4'(t), 0, 0);
      chk("lim_grant", s_grant, 2'b01);
    end
    apply(1, 32'h2000, 0, 0, 0, 9, 0, 0);
    chk("lim9_grant", s_grant, 2'b00);
    chk("lim9_pcmd", s_pcmd, 2'd0);
    apply(1, 32'h2000, 0, 0, 0, 9, 1, 64'hab);
    chk("lim_done_grant", s_grant, 2'b00);
    chk("lim_done_itag", s_itag, 4'd1);
    apply(1, 32'h2000, 0, 0, 0, 9, 0, 0);
    chk("lim9_after_grant", s_grant, 2'b01);
    chk("lim9_after_iresp", s_iresp, 4'd9);
    bus.icache2arb_command = '0;
    bus.mem2proc_response  = '0;
    bus.mem2proc_tag       = 4'd5;
    #1;
    chk("pre_rst_itag", bus.arb2icache_tag, 4'd5);
    rst = 1'b1;
    #1;
    chk("async_rst_itag", bus.arb2icache_tag, 4'd0);
    do_reset();
    apply(0, 0, 0, 0, 0, 0, 5, 64'h5555);
    chk("post_rst_itag", s_itag, 4'd0);
    chk("post_rst_dtag", s_dtag, 4'd0);
    for (int t = 1; t <= 8; t++) begin
      apply(1, 32'h3000 + t, 0, 0, 0, 4'(t), 0, 0);
      chk("post_rst_cnt_grant", s_grant, 2'b01);
    end
    for (int n = 0; n < 400; n++) begin
      ic = 2'($urandom_range(0, 1));
      dc = 2'($urandom_range(0, 2));
      keys = {};
      foreach (owner[k]) keys.push_back(k);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: mt = keys.size() > 0 ? 4'(keys[$urandom_range(0, keys.size() - 1)]) : 4'd0;
        5, 6:          mt = 4'($urandom_range(0, 15));
        default:       mt = 4'd0;
      endcase
      rs = 4'd0;
      if ($urandom_range(0, 9) < 7)
        for (int k = 0; k < 16; k++) begin
          int t = $urandom_range(1, 15);
          if (!owner.exists(t) || t == int'(mt)) begin
            rs = 4'(t);
            break;
          end
        end
      apply(ic, $urandom, dc, $urandom, {$urandom, $urandom}, rs, mt, {$urandom, $urandom});
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(1, 32'h400, 2, 32'h800, 64'(k), 4'(k + 1), 0, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("rr_grant", s_grant, k % 2 == 0 ? 2'b10 : 2'b01);
`else
      chk("fixed_grant", s_grant, 2'b10);
`endif
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single tagged memory port between the icache and the dcache.
- Grants one requester per cycle and forwards its command, address and data to memory.
- Records which requester owns each accepted load tag, and routes each returning tagged data beat back to that owner only.
- Sits between icache/dcache and the memory model. Each cache sees a private memory interface with identical response/tag semantics.

Parameters:
- NUM_TAGS, 15: number of legal nonzero memory tags (1..NUM_TAGS); sizes the owner table.
- MAX_OUTSTANDING, 8: maximum loads in flight per requester; a requester at its limit is masked from arbitration.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- icache2arb_command  in  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2 (icache issues loads only)
- icache2arb_addr  in  32  icache request address
- arb2icache_response  out  4  accepting tag for the icache request this cycle; 0 = not accepted
- arb2icache_data  out  64  returning data routed to the icache
- arb2icache_tag  out  4  completing tag routed to the icache; 0 = none
- dcache2arb_command  in  2  dcache command
- dcache2arb_addr  in  32  dcache request address
- dcache2arb_data  in  64  store data
- arb2dcache_response  out  4  accepting tag for the dcache request; 0 = not accepted
- arb2dcache_data  out  64  returning data routed to the dcache
- arb2dcache_tag  out  4  completing tag routed to the dcache
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  32  address to memory
- proc2mem_data  out  64  store data to memory
- mem2proc_response  in  4  memory accept tag; 0 = rejected
- mem2proc_data  in  64  returning load data
- mem2proc_tag  in  4  completing tag; 0 = none
- arb_grant  out  2  bit0 = icache granted, bit1 = dcache granted (one-hot or zero)

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high.
- Reset state: owner table all invalid; both outstanding counters 0; last_grant = icache.
- Request path (combinational): a requester is eligible when its command != BUS_NONE and (command == BUS_STORE or its outstanding count < MAX_OUTSTANDING).
- Grant priority: dcache over icache (fixed). Exactly one eligible requester is granted per cycle.
- Granted requester: its command/addr/data drive proc2mem_*.
- No grant: proc2mem_command = BUS_NONE, proc2mem_addr = 0, proc2mem_data = 0.
- arb2X_response: equals mem2proc_response for the granted requester; 0 for the other. The requester retries on 0.
- Recording an accepted load (posedge): when the granted command is BUS_LOAD and mem2proc_response != 0, set owner[response] = granted requester, set valid[response], and increment that requester's count.
- Stores: accepted stores are not recorded and return no data.
- Completion (posedge): when mem2proc_tag != 0 and valid[tag], clear valid[tag] and decrement the owner's count.
- Completion routing (combinational): in the same cycle, the owner sees arb2X_tag = mem2proc_tag and arb2X_data = mem2proc_data. The non-owner sees tag 0 and data 0.
- Unmatched completion: a tag that is not valid is dropped and reaches neither requester.
- Same tag completing and accepted in one cycle: the completion routes to the old owner, and the new owner entry is written (set wins over clear).
- Simultaneous increment and decrement on one counter: net count is unchanged.
- Counter range: counters are $clog2(MAX_OUTSTANDING+1) bits wide and never exceed MAX_OUTSTANDING.
- Reset mid-operation: all entries are cleared. Later completions carrying pre-reset tags are dropped.
- Latency: zero-cycle request forwarding and zero-cycle completion routing. The owner table is updated at the next posedge.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined: on a cycle where both requesters are eligible, grant the one that is not last_grant. last_grant updates on every cycle with a grant.
- When undefined: fixed dcache priority and no last_grant register. The icache can starve while the dcache keeps requesting.

Test Plan:
- Icache LOAD 0x400 only, memory response 1; three cycles later mem tag 1, data 0xdeadbeefcafebabe -> arb2icache_response = 1, arb_grant = 01; arb2icache_tag = 1 with that data; arb2dcache_tag = 0.
- Icache LOAD 0x400 and dcache LOAD 0x800 in the same cycle, response 2 -> dcache granted, arb2dcache_response = 2, arb2icache_response = 0. The icache is granted the following cycle with response 3. Tags 3 and 2 later route to icache and dcache respectively.
- Icache issues 8 loads, all accepted with no completions -> the 9th request sees arb_grant = 00 and proc2mem_command = 0. After one completion, the 9th is granted.
- Dcache STORE 0x100, data 0x55, response 4; later mem tag 4 -> the store is not recorded and tag 4 is dropped (both arb2X_tag = 0).
- Reset asserted while tags 5 and 6 are outstanding; mem tag 5 arrives after deassert -> dropped; counters read 0.
- With MEM_ARB_ROUND_ROBIN_EN, both caches request continuously and memory always accepts -> grants alternate 10, 01, 10, 01. Without the macro -> grant stays 10.
